// File: rtl/framed_serial_to_parallel.sv
// Serial-to-parallel receiver: shifts qualified bits in, latches each complete
// WIDTH-bit frame into a holding register, and resynchronises on frameSync.
module framed_serial_to_parallel #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     shiftEnable,
  input  logic                     dataIn,
  input  logic                     frameSync,
  input  logic                     outputEnable,
  output logic [WIDTH-1:0]         outputs,
  output logic                     dataOut,
  output logic                     frameValid,
  output logic                     frameError,
  output logic [$clog2(WIDTH)-1:0] bitCount
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] hold_reg;
  logic [CW-1:0]    count_reg;
  logic             valid_reg;
  logic             error_reg;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_next = {shift_reg[WIDTH-2:0], dataIn};
      assign dataOut    = shift_reg[WIDTH-1];
    end else begin : g_lsb_first
      assign shift_next = {dataIn, shift_reg[WIDTH-1:1]};
      assign dataOut    = shift_reg[0];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!resetN) begin
      shift_reg <= '0;
      hold_reg  <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
      if (shiftEnable) begin
        shift_reg <= shift_next;
        if (frameSync) begin
          count_reg <= CW'(1);
          error_reg <= (count_reg != '0);
        end else if (count_reg == LAST_BIT) begin
          count_reg <= '0;
          hold_reg  <= shift_next;
          valid_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + CW'(1);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gate
      assign outputs[gi] = outputEnable & hold_reg[gi];
    end
  endgenerate

  assign frameValid = valid_reg;
  assign frameError = error_reg;
  assign bitCount   = count_reg;

endmodule

// File: tb/tb_framed_serial_to_parallel.sv
// Directed bench for framed_serial_to_parallel: an MSB-first and an LSB-first
// instance share all inputs; expectations are hand-computed words.
module tb_framed_serial_to_parallel;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       shift_enable = 1'b0;
  logic       data_in = 1'b0;
  logic       frame_sync = 1'b0;
  logic       output_enable = 1'b1;
  logic [7:0] outputs_m, outputs_l;
  logic       dout_m, dout_l, valid_m, valid_l, err_m, err_l;
  logic [2:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [7:0] hold_exp;

  always #5 clock = ~clock;

  framed_serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .resetN(reset_n), .shiftEnable(shift_enable), .dataIn(data_in),
    .frameSync(frame_sync), .outputEnable(output_enable), .outputs(outputs_m),
    .dataOut(dout_m), .frameValid(valid_m), .frameError(err_m), .bitCount(cnt_m));

  framed_serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .resetN(reset_n), .shiftEnable(shift_enable), .dataIn(data_in),
    .frameSync(frame_sync), .outputEnable(output_enable), .outputs(outputs_l),
    .dataOut(dout_l), .frameValid(valid_l), .frameError(err_l), .bitCount(cnt_l));

  typedef struct {
    logic       rst_n, se, din, fs, oe;
    logic [7:0] out_m, out_l;
    logic       valid, err, dout_m, dout_l;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick(input logic se, input logic d, input logic fs);
    shift_enable = se;
    data_in      = d;
    frame_sync   = fs;
    @(posedge clock);
    #1;
  endtask

  // Sends one qualified bit and checks both instances against expected state.
  task automatic send_bit(input string tag, input logic d, input logic fs,
                          input logic [7:0] word, input logic ev, input logic ee,
                          input logic [2:0] ecnt);
    logic [7:0] gated;
    tick(1'b1, d, fs);
    gated = output_enable ? word : 8'h00;
    chk({tag, "_out_m"}, outputs_m, gated);
    chk({tag, "_out_l"}, outputs_l, rev8(gated));
    chk({tag, "_valid"}, {valid_m, valid_l}, {ev, ev});
    chk({tag, "_err"}, {err_m, err_l}, {ee, ee});
    chk({tag, "_cnt"}, {cnt_m, cnt_l}, {ecnt, ecnt});
    if (valid_m) pulses++;
  endtask

  // Full 8-bit frame, first bit optionally carrying frameSync.
  task automatic send_frame(input string tag, input logic [7:0] word,
                            input logic fs, input logic ee);
    send_bit(tag, word[7], fs, hold_exp, 1'b0, ee, 3'd1);
    for (int i = 6; i >= 1; i--)
      send_bit(tag, word[i], 1'b0, hold_exp, 1'b0, 1'b0, 3'(8 - i));
    send_bit(tag, word[0], 1'b0, word, 1'b1, 1'b0, 3'd0);
    hold_exp = word;
  endtask

  // Frame with random idle edges between bits (never before the first bit).
  task automatic send_gapped(input string tag, input logic [7:0] word);
    int g;
    for (int i = 7; i >= 0; i--) begin
      if (i != 7) begin
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          tick(1'b0, 1'b0, 1'b0);
          chk({tag, "_gap_out"}, outputs_m, hold_exp);
          chk({tag, "_gap_valid"}, valid_m, 1'b0);
        end
      end
      if (i == 0) send_bit(tag, word[0], 1'b0, word, 1'b1, 1'b0, 3'd0);
      else        send_bit(tag, word[i], 1'b0, hold_exp, 1'b0, 1'b0, 3'(8 - i));
    end
    hold_exp = word;
  endtask

  initial begin
    logic [7:0] seq;
    logic       last;
    seq = 8'b1011_0101;

    // Reset, word capture of B5/AD, idle hold, fs ignored while disabled.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    for (int k = 1; k <= 8; k++) begin
      last = (k == 8);
      vecs[k] = '{1'b1, 1'b1, seq[8-k], 1'b0, 1'b1,
                  last ? 8'hB5 : 8'h00, last ? 8'hAD : 8'h00,
                  last, 1'b0, last, last, 3'(k % 8)};
    end
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB5, 8'hAD, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};

    for (int i = 0; i < 11; i++) begin
      reset_n       = vecs[i].rst_n;
      output_enable = vecs[i].oe;
      tick(vecs[i].se, vecs[i].din, vecs[i].fs);
      chk($sformatf("vec%0d_out_m", i), outputs_m, vecs[i].out_m);
      chk($sformatf("vec%0d_out_l", i), outputs_l, vecs[i].out_l);
      chk($sformatf("vec%0d_valid", i), {valid_m, valid_l}, {vecs[i].valid, vecs[i].valid});
      chk($sformatf("vec%0d_err", i), {err_m, err_l}, {vecs[i].err, vecs[i].err});
      chk($sformatf("vec%0d_dout_m", i), dout_m, vecs[i].dout_m);
      chk($sformatf("vec%0d_dout_l", i), dout_l, vecs[i].dout_l);
      chk($sformatf("vec%0d_cnt", i), cnt_m, vecs[i].cnt);
    end
    output_enable = 1'b1;
    hold_exp = 8'hB5;

    // Throttled back-to-back words.
    pulses = 0;
    send_gapped("thr3c", 8'h3C);
    send_gapped("thrff", 8'hFF);
    send_gapped("thr00", 8'h00);
    chk("thr_pulses", pulses, 3);

    // Resync after 3 bits.
    send_bit("rs_pre", 1'b1, 1'b0, hold_exp, 1'b0, 1'b0, 3'd1);
    send_bit("rs_pre", 1'b1, 1'b0, hold_exp, 1'b0, 1'b0, 3'd2);
    send_bit("rs_pre", 1'b1, 1'b0, hold_exp, 1'b0, 1'b0, 3'd3);
    send_frame("rs81", 8'h81, 1'b1, 1'b1);

    // Resync exactly at bitCount=7 drops the frame.
    for (int i = 1; i <= 7; i++)
      send_bit("drop_pre", 1'(i % 2), 1'b0, hold_exp, 1'b0, 1'b0, 3'(i));
    send_frame("drop5a", 8'h5A, 1'b1, 1'b1);

    // Output gating while the next word (C3) streams in.
    output_enable = 1'b0;
    send_bit("gate", 1'b1, 1'b0, hold_exp, 1'b0, 1'b0, 3'd1);
    send_bit("gate", 1'b1, 1'b0, hold_exp, 1'b0, 1'b0, 3'd2);
    send_bit("gate", 1'b0, 1'b0, hold_exp, 1'b0, 1'b0, 3'd3);
    send_bit("gate", 1'b0, 1'b0, hold_exp, 1'b0, 1'b0, 3'd4);
    output_enable = 1'b1;
    #1;
    chk("gate_reenable", outputs_m, 8'h5A);
    send_bit("gate", 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 3'd5);
    send_bit("gate", 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 3'd6);
    send_bit("gate", 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 3'd7);
    send_bit("gatec3", 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 3'd0);
    hold_exp = 8'hC3;

    // Reset five bits into a frame.
    for (int i = 1; i <= 5; i++)
      send_bit("rst_pre", 1'(i % 2), 1'b0, hold_exp, 1'b0, 1'b0, 3'(i));
    reset_n = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    chk("rst_out", outputs_m, 8'h00);
    chk("rst_cnt", {cnt_m, cnt_l}, 6'd0);
    chk("rst_dout", {dout_m, dout_l}, 2'b00);
    chk("rst_strobes", {valid_m, err_m}, 2'b00);
    hold_exp = 8'h00;
    // frameSync at bitCount=0 is a clean resync: no error.
    send_frame("rst42", 8'h42, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
